// File: rtl/lcd_min_pkg.sv
// Shared FSM encodings and ASCII constants for the LCD minimum finder.
// Also holds the hex-digit-to-ASCII helper used when building display lines.
package lcd_min_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FORMAT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

    localparam logic [31:0] STR_MIN  = "MIN=";
    localparam logic [31:0] STR_POS  = "POS=";
    localparam logic [31:0] STR_WAIT = "WAIT";

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10)
            return ASC_ZERO + {4'h0, v};
        else
            return ASC_A + {4'h0, v - 4'd10};
    endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Two-flop synchroniser for one raw push-button plus rising-edge detector.
// A press yields exactly one single-cycle pulse.
module pb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic pulse
);

    logic s1, s2, s3;

    // Synchronise the button and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pb;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/lcd_min_param.sv
// Captures switch values into channels on button presses, scans for the
// minimum one channel per cycle and renders both LCD text lines.
module lcd_min_param
    import lcd_min_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 3,
    parameter int POS_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] slide,
    input  logic [NUM_CH-1:0] pb,
    output logic [127:0]      first_line,
    output logic [127:0]      second_line,
    output logic [DATA_W-1:0] min_val,
    output logic [POS_W-1:0]  min_pos,
    output logic              valid,
    output logic              busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    localparam logic [127:0] LINE_WAIT = {STR_WAIT, {12{ASC_SPACE}}};

    logic [NUM_CH-1:0] load;
    logic [DATA_W-1:0] ch [NUM_CH];
    logic [NUM_CH-1:0] loaded;
    logic              pending;
    logic              all_loaded;
    logic              any_load;
    logic              last_idx;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] scan_min;
    logic [IDX_W-1:0]  scan_pos;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_sync
            pb_sync_edge u_sync (
                .clk   (clk),
                .rst   (rst),
                .pb    (pb[g]),
                .pulse (load[g])
            );
        end
    endgenerate

    assign all_loaded = &loaded;
    assign any_load   = |load;
    assign last_idx   = (idx == IDX_W'(NUM_CH - 1));

    // Capture the switch value into every channel whose button fired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                ch[i] <= '0;
            loaded <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i]) begin
                    ch[i]     <= slide;
                    loaded[i] <= 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a load seen while busy forces an immediate rescan
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (all_loaded) state_d = ST_SCAN;
            ST_SCAN:   if (last_idx) state_d = ST_FORMAT;
            ST_FORMAT: state_d = (pending | any_load) ? ST_SCAN : ST_DONE;
            ST_DONE:   if (any_load) state_d = ST_SCAN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy  = (state_q == ST_SCAN) || (state_q == ST_FORMAT);
        valid = (state_q == ST_DONE);
    end

    // Remember loads that arrive while a scan is already underway
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if (state_q == ST_FORMAT)
            pending <= 1'b0;
        else if (any_load && state_q == ST_SCAN)
            pending <= 1'b1;
    end

    // Sequential minimum search; strict less-than keeps the lowest index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            scan_min <= '0;
            scan_pos <= '0;
        end else if (state_q == ST_SCAN) begin
            idx <= last_idx ? '0 : idx + 1'b1;
            if (idx == '0 || ch[idx] < scan_min) begin
                scan_min <= ch[idx];
                scan_pos <= idx;
            end
        end else begin
            idx <= '0;
        end
    end

    // Publish the result and the summary line only once the scan finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val     <= '0;
            min_pos     <= '0;
            second_line <= LINE_WAIT;
        end else if (!all_loaded) begin
            second_line <= LINE_WAIT;
        end else if (state_q == ST_FORMAT) begin
            min_val     <= scan_min;
            min_pos     <= POS_W'(scan_pos);
            second_line <= {STR_MIN, hex_char(4'(scan_min)), ASC_SPACE,
                            STR_POS, hex_char(4'(scan_pos)),
                            {5{ASC_SPACE}}};
        end
    end

    // Channel line follows the channel registers directly
    always_comb begin
        first_line = {16{ASC_SPACE}};
        for (int i = 0; i < NUM_CH; i++) begin
            first_line[8*(15-2*i) +: 8] =
                loaded[i] ? hex_char(4'(ch[i])) : ASC_DASH;
            first_line[8*(14-2*i) +: 8] = ASC_COMMA;
        end
    end

endmodule

// File: tb/tb_lcd_min_param.sv
// Directed bench for lcd_min_param with a scoreboard of expected results.
// Expected lines are written out as literal strings.
module tb_lcd_min_param;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   slide;
    logic [3:0]   pb;
    logic [127:0] first_line;
    logic [127:0] second_line;
    logic [2:0]   min_val;
    logic [2:0]   min_pos;
    logic         valid;
    logic         busy;

    int total  = 0;
    int failed = 0;

    typedef struct {
        string        tag;
        logic [2:0]   mv;
        logic [2:0]   mp;
        logic [127:0] fl;
        logic [127:0] sl;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] L_WAIT = "WAIT            ";
    localparam logic [127:0] L_DASH = "-,-,-,-,        ";

    lcd_min_param #(.NUM_CH(4), .DATA_W(3), .POS_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .slide       (slide),
        .pb          (pb),
        .first_line  (first_line),
        .second_line (second_line),
        .min_val     (min_val),
        .min_pos     (min_pos),
        .valid       (valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic press_nowait(input logic [3:0] mask, input logic [2:0] v);
        slide = v;
        pb    = mask;
        tick(1);
        pb    = '0;
    endtask

    task automatic press(input logic [3:0] mask, input logic [2:0] v);
        press_nowait(mask, v);
        tick(4);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 40) begin
            tick(1);
            n++;
        end
        chk("busy_seen", 128'(busy), 128'd1);
    endtask

    task automatic wait_valid(input bit check_lat);
        int lat = 0;
        exp_t e;
        while (!valid && lat < 60) begin
            tick(1);
            lat++;
        end
        if (check_lat)
            chk("latency", 128'(lat), 128'd5);
        if (sb.size() == 0) begin
            chk("sb_empty", 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, 128'(valid), 128'd1);
            chk({e.tag, "_minval"}, 128'(min_val), 128'(e.mv));
            chk({e.tag, "_minpos"}, 128'(min_pos), 128'(e.mp));
            chk({e.tag, "_line1"}, first_line, e.fl);
            chk({e.tag, "_line2"}, second_line, e.sl);
            chk({e.tag, "_busy"}, 128'(busy), 128'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_minval"}, 128'(min_val), 128'd0);
        chk({tag, "_minpos"}, 128'(min_pos), 128'd0);
        chk({tag, "_line1"}, first_line, L_DASH);
        chk({tag, "_line2"}, second_line, L_WAIT);
    endtask

    initial begin
        rst   = 1'b1;
        slide = '0;
        pb    = '0;
        tick(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Partial load: only two channels captured
        press(4'b0001, 3'd5);
        press(4'b0010, 3'd3);
        tick(3);
        chk("partial_valid", 128'(valid), 128'd0);
        chk("partial_busy", 128'(busy), 128'd0);
        chk("partial_line1", first_line, "5,3,-,-,        ");
        chk("partial_line2", second_line, L_WAIT);

        // Complete the set: 5,3,6,2
        press(4'b0100, 3'd6);
        sb.push_back('{"basic", 3'd2, 3'd3,
                       "5,3,6,2,        ", "MIN=2 POS=3     "});
        press_nowait(4'b1000, 3'd2);
        wait_busy();
        wait_valid(1'b1);

        // Fresh set with a tie and a simultaneous two-button press
        rst = 1'b1;
        #2;
        check_reset_outputs("rst2");
        rst = 1'b0;
        tick(2);
        press(4'b0001, 3'd4);
        press(4'b0110, 3'd1);
        sb.push_back('{"tie", 3'd1, 3'd1,
                       "4,1,1,7,        ", "MIN=1 POS=1     "});
        press_nowait(4'b1000, 3'd7);
        wait_busy();
        wait_valid(1'b1);

        // Reload from DONE starts a new scan
        sb.push_back('{"reload", 3'd0, 3'd2,
                       "4,1,0,7,        ", "MIN=0 POS=2     "});
        press_nowait(4'b0100, 3'd0);
        wait_busy();
        wait_valid(1'b1);

        // Load during a scan forces a rescan with valid held low
        press_nowait(4'b1000, 3'd7);
        wait_busy();
        press_nowait(4'b0001, 3'd0);
        tick(4);
        chk("midscan_valid", 128'(valid), 128'd0);
        chk("midscan_busy", 128'(busy), 128'd1);
        sb.push_back('{"rescan", 3'd0, 3'd0,
                       "0,1,0,7,        ", "MIN=0 POS=0     "});
        wait_valid(1'b0);

        // Simultaneous press of pb1 and pb2 with 7
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick(2);
        press(4'b0110, 3'd7);
        tick(1);
        chk("simul_line1", first_line, "-,7,7,-,        ");
        chk("simul_valid", 128'(valid), 128'd0);

        // Reset in the middle of a scan
        press_nowait(4'b1001, 3'd2);
        wait_busy();
        tick(2);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("postrst_valid", 128'(valid), 128'd0);
        chk("postrst_busy", 128'(busy), 128'd0);
        chk("postrst_line1", first_line, L_DASH);

        // Four fresh loads after reset
        press(4'b0001, 3'd6);
        press(4'b0010, 3'd5);
        press(4'b0100, 3'd4);
        chk("fresh_valid", 128'(valid), 128'd0);
        sb.push_back('{"fresh", 3'd4, 3'd2,
                       "6,5,4,7,        ", "MIN=4 POS=2     "});
        press_nowait(4'b1000, 3'd7);
        wait_busy();
        wait_valid(1'b1);

        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
